ntt_scheduler: RTL and testbench
================================

# ntt_scheduler

Sequencing controller for the butterfly datapath: runs a full 256-point Kyber (q = 3329) forward NTT or inverse NTT over a dual-port coefficient RAM by issuing one butterfly per cycle. Per butterfly it generates RAM read addresses, the twiddle-ROM index, the CT/GS select, and write-back addresses delayed to match the read-plus-butterfly pipeline. It drains the pipeline between layers so no read-after-write hazard reaches the RAM. It sits between the polynomial-multiplier top-level control and the butterfly/RAM/ROM datapath.

## Interface
- RD_LAT, 1, coefficient RAM read latency in cycles
- BF_LAT, 4, latency of the registered butterfly from operand input to E/O output
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a transform; sampled only in IDLE
- mode  in  1  0 = forward NTT (CT), 1 = inverse NTT (GS); latched with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  single-cycle pulse after the last write-back of layer 6
- layer  out  3  current layer 0..6
- ct  out  1  butterfly CT select, equals ~latched mode
- rd_en  out  1  read strobe for both RAM ports
- rd_addr_a, rd_addr_b  out  8  even/odd operand addresses
- tw_addr  out  7  twiddle ROM index, valid with rd_en
- wr_en  out  1  write strobe for both RAM ports
- wr_addr_a, wr_addr_b  out  8  write-back addresses for E and O

## Operation
- PIPE = RD_LAT + BF_LAT, with a default of 5.
- FSM states are IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If start is high: latch mode, clear layer and the 7-bit butterfly counter bf, and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - rd_en is high, and one butterfly issues per cycle for bf = 0..127.
  - After bf = 127: go to DRAIN and load the drain counter with PIPE.
- DRAIN:
  - rd_en is low; the drain counter counts down PIPE cycles.
  - When it expires, if layer < 6: increment layer, clear bf, and go to ISSUE.
  - Otherwise go to DONE.
- DONE: done = 1 for one cycle, busy = 0, then go to IDLE.
- Address generation, with L = log2(len), group = bf >> L, offset = bf & (len−1):
  - Forward: len = 128 >> layer.
  - Inverse: len = 2 << layer.
  - rd_addr_a = group·2·len + offset.
  - rd_addr_b = rd_addr_a + len.
- Twiddle index:
  - Forward: tw_addr = (1 << layer) + group.
  - Inverse: tw_addr = (128 >> layer) − 1 − group.
- Write-back path:
  - rd_en, rd_addr_a and rd_addr_b go through a PIPE-deep shift register.
  - Its outputs are wr_en, wr_addr_a and wr_addr_b.
  - wr_* addresses equal the rd_* addresses exactly PIPE cycles earlier.
- start while busy is ignored, and mode changes while busy are ignored.
- ct is held constant for the whole transform.
- Asynchronous reset (rst_n low), including mid-transform:
  - FSM returns to IDLE, and all counters and pipeline stages clear.
  - All outputs go to 0, and no wr_en pulse follows release.
- All address arithmetic is unsigned and fits in 8 bits; overflow cannot occur.

## Timing
- Cycle 0: start sampled. Cycle 1: first issue (layer 0, bf 0); busy rises.
- Layer n issues on cycles 1 + n·(128 + PIPE) through 128 + n·(128 + PIPE).
- The first wr_en of a layer comes PIPE cycles after its first rd_en.
- The last wr_en of a layer is on the final DRAIN cycle.
- The next layer's first read comes one cycle later, so RAM writes are visible (write-first not required).
- Total: done at cycle 1 + 7·(128 + PIPE), which is 932 at the defaults; busy low on that cycle.
- rd_en duty is 128 of every 128 + PIPE cycles while busy.
- wr_en is never high in IDLE or DONE.
- Reset values: every output is 0.

## Test plan
- Forward, defaults, start at cycle 0:
  - Layer 0, bf 5 → rd_addr_a 5, rd_addr_b 133, tw_addr 1, ct 1.
  - Layer 1, bf 70 → 134/198, tw_addr 3.
  - Layer 6, bf 127 → 253/255, tw_addr 127.
  - done exactly at cycle 932.
- Inverse, defaults:
  - Layer 0, bf 0 → 0/2, tw_addr 127, ct 0.
  - Layer 6, bf 0 → 0/128, tw_addr 1.
  - Each address pair is written once per layer.
- Write-back alignment: for every cycle, wr_en/wr_addr_* equal rd_en/rd_addr_* from 5 cycles earlier. Check with RD_LAT = 2, BF_LAT = 6 (PIPE = 8, done at cycle 953).
- Coverage: each layer's 128 issues cover all 256 addresses exactly once, with no read of an address pending write.
- Start pulses and mode toggles while busy → no effect on addresses, ct, or done time.
- rst_n low for 1 cycle at cycle 300 → all outputs 0 immediately; no further wr_en. A new start after release gives a full 932-cycle run.

Source files
------------

// File: rtl/ntt_scheduler_if.sv
// ntt_scheduler_if
//   Groups the control and datapath-facing signals of the NTT scheduler.
//
//   Control side : start, mode (into the scheduler); busy, done, layer, ct.
//   Read side    : rd_en, rd_addr_a, rd_addr_b, tw_addr.
//   Write side   : wr_en, wr_addr_a, wr_addr_b.
//
//   Handshake: start is a request that is accepted only while the scheduler
//   is idle (busy low and done low). Acceptance is visible as busy rising on
//   the next cycle. Once accepted, start and mode are ignored until the
//   single-cycle done pulse, on which busy is already low. No back-pressure
//   exists on the RAM side: rd_en/wr_en are strobes that the datapath must
//   honour in the cycle they are high.
//
//   Modports:
//     master : the scheduler itself.
//     slave  : the surrounding control/datapath that talks to it.
interface ntt_scheduler_if;
  logic       start;
  logic       mode;
  logic       busy;
  logic       done;
  logic [2:0] layer;
  logic       ct;
  logic       rd_en;
  logic [7:0] rd_addr_a;
  logic [7:0] rd_addr_b;
  logic [6:0] tw_addr;
  logic       wr_en;
  logic [7:0] wr_addr_a;
  logic [7:0] wr_addr_b;

  modport master (
    input  start, mode,
    output busy, done, layer, ct,
    output rd_en, rd_addr_a, rd_addr_b, tw_addr,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, mode,
    input  busy, done, layer, ct,
    input  rd_en, rd_addr_a, rd_addr_b, tw_addr,
    input  wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_scheduler.sv
// ntt_scheduler
//   Sequencer for a 256-point Kyber NTT / inverse NTT over a dual-port
//   coefficient RAM. Issues one butterfly per cycle (128 per layer, 7 layers),
//   generating operand read addresses, the twiddle ROM index and the CT/GS
//   select. Read addresses are delayed through a PIPE-deep shift register to
//   become the write-back addresses, and the pipeline is drained between
//   layers so the next layer never reads a coefficient still in flight.
//
//   Parameters:
//     RD_LAT : coefficient RAM read latency (cycles)
//     BF_LAT : butterfly latency, operands in to E/O out (cycles)
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset
//     bus       : ntt_scheduler_if.master (start/mode in, everything else out)
//     dbg_state : current FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 DONE)
module ntt_scheduler #(
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ntt_scheduler_if.master        bus,
  output logic [1:0]             dbg_state
);

  localparam int       PIPE       = RD_LAT + BF_LAT;
  localparam logic [7:0] DRAIN_LOAD = 8'(PIPE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] layer_q, layer_d;
  logic [6:0] bf_q,    bf_d;
  logic [7:0] drain_q, drain_d;
  // ct_q doubles as the latched mode: 1 = forward (CT), 0 = inverse (GS).
  logic       ct_q,    ct_d;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      layer_q <= 3'd0;
      bf_q    <= 7'd0;
      drain_q <= 8'd0;
      ct_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      bf_q    <= bf_d;
      drain_q <= drain_d;
      ct_q    <= ct_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    bf_d    = bf_q;
    drain_d = drain_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ct_d    = ~bus.mode;
          layer_d = 3'd0;
          bf_d    = 7'd0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // bf wraps 127 -> 0 on its own, leaving it cleared for the next layer.
        bf_d = bf_q + 7'd1;
        if (bf_q == 7'd127) begin
          state_d = DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      DRAIN: begin
        // drain_q == 1 marks the last drain cycle: the final write-back of
        // the layer happens in this cycle.
        if (drain_q == 8'd1) begin
          if (layer_q < 3'd6) begin
            layer_d = layer_q + 3'd1;
            bf_d    = 7'd0;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end else begin
          drain_d = drain_q - 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Address generation
  //   lg = log2(len): forward len = 128 >> layer, inverse len = 2 << layer.
  //   group = bf >> lg, offset = bf & (len-1)
  //   a = group*2*len + offset, b = a + len
  // ---------------------------------------------------------------------
  logic       rd_en;
  logic [2:0] lg;
  logic [6:0] grp, mask, off, tw;
  logic [7:0] base, len8, rd_a, rd_b;

  always_comb begin
    lg   = ct_q ? (3'd7 - layer_q) : (layer_q + 3'd1);
    grp  = bf_q >> lg;
    // len-1 without ever forming len=128 in 7 bits.
    mask = ~(7'h7f << lg);
    off  = bf_q & mask;
    len8 = 8'd1 << lg;
    base = {1'b0, grp} << lg;
    rd_a = (base << 1) + {1'b0, off};
    rd_b = rd_a + len8;
    // 127 >> layer == (128 >> layer) - 1 for layer 0..6.
    tw   = ct_q ? ((7'd1 << layer_q) + grp) : ((7'd127 >> layer_q) - grp);
  end

  assign rd_en = (state_q == ISSUE);

  // ---------------------------------------------------------------------
  // Write-back delay line: {rd_en, rd_addr_a, rd_addr_b} delayed PIPE cycles.
  // Addresses are gated with rd_en, so idle stages always carry zeros.
  // ---------------------------------------------------------------------
  logic [16:0] wb_q [PIPE];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE; i++) wb_q[i] <= '0;
    end else begin
      wb_q[0] <= {rd_en, bus.rd_addr_a, bus.rd_addr_b};
      for (int i = 1; i < PIPE; i++) wb_q[i] <= wb_q[i-1];
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.busy      = (state_q == ISSUE) || (state_q == DRAIN);
  assign bus.done      = (state_q == DONE);
  assign bus.layer     = layer_q;
  assign bus.ct        = ct_q;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr_a = rd_en ? rd_a : 8'd0;
  assign bus.rd_addr_b = rd_en ? rd_b : 8'd0;
  assign bus.tw_addr   = rd_en ? tw   : 7'd0;
  assign bus.wr_en     = wb_q[PIPE-1][16];
  assign bus.wr_addr_a = wb_q[PIPE-1][15:8];
  assign bus.wr_addr_b = wb_q[PIPE-1][7:0];
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_ntt_scheduler.sv
// tb_ntt_scheduler
//   Drives two schedulers in lockstep: one at default latencies (PIPE = 5)
//   and one with RD_LAT = 2, BF_LAT = 6 (PIPE = 8). A per-cycle monitor
//   compares every output against an address model written from the
//   len/group/offset definition; expected write-backs are queued when a read
//   is expected and popped when they fall due.
module tb_ntt_scheduler;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // ---------------- DUTs ----------------
  logic       start, mode;
  logic [1:0] dbg5, dbg8;

  ntt_scheduler_if bus5 ();
  ntt_scheduler_if bus8 ();

  assign bus5.start = start;
  assign bus5.mode  = mode;
  assign bus8.start = start;
  assign bus8.mode  = mode;

  ntt_scheduler #(.RD_LAT(1), .BF_LAT(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .bus(bus5), .dbg_state(dbg5)
  );
  ntt_scheduler #(.RD_LAT(2), .BF_LAT(6)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bus8), .dbg_state(dbg8)
  );

  // ---------------- scoreboard state ----------------
  int          n_assert = 0;
  int          n_fail   = 0;
  bit          run_on   = 1'b0;
  int          t_start  = 0;
  logic        run_mode = 1'b0;
  logic [2:0]  idle_layer = 3'd0;
  logic        idle_ct    = 1'b0;
  logic [31:0] exp_q[$];   // PIPE 5: {due cycle[15:0], addr_a, addr_b}
  logic [31:0] exp_q8[$];  // PIPE 8
  logic [255:0] seen [2];

  task automatic chk(input int id, input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL dut%0d %s: observed %0d expected %0d", id, tag, obs, exp);
    end
  endtask

  function automatic int q_size(input int id);
    return (id == 0) ? exp_q.size() : exp_q8.size();
  endfunction

  function automatic logic [31:0] q_get(input int id, input int i);
    return (id == 0) ? exp_q[i] : exp_q8[i];
  endfunction

  task automatic q_push(input int id, input logic [31:0] v);
    if (id == 0) exp_q.push_back(v);
    else         exp_q8.push_back(v);
  endtask

  task automatic q_pop(input int id);
    if (id == 0) void'(exp_q.pop_front());
    else         void'(exp_q8.pop_front());
  endtask

  // Reference addresses from the len/group/offset definition.
  function automatic void model(input logic inv, input int lay, input int bf,
                                output logic [7:0] a, output logic [7:0] b,
                                output logic [6:0] tw);
    int len, grp, off, ai, ti;
    len = inv ? (2 << lay) : (128 >> lay);
    grp = bf / len;
    off = bf % len;
    ai  = grp * 2 * len + off;
    ti  = inv ? ((128 >> lay) - 1 - grp) : ((1 << lay) + grp);
    a   = ai[7:0];
    b   = 8'(ai + len);
    tw  = ti[6:0];
  endfunction

  // Per-cycle monitor for one DUT.
  task automatic mon(input int id, input int pipe, input logic [1:0] dbg,
                     input logic busy, input logic done, input logic [2:0] layer,
                     input logic ct, input logic rd_en, input logic [7:0] rd_a,
                     input logic [7:0] rd_b, input logic [6:0] tw,
                     input logic wr_en, input logic [7:0] wr_a, input logic [7:0] wr_b);
    int rel, per, n, k, qn;
    logic [7:0]  ea, eb;
    logic [6:0]  et;
    logic [31:0] ent;
    logic        hz, dup;
    per = 128 + pipe;
    rel = edge_cnt - t_start;
    if (!run_on || rel < 1 || rel > 7 * per + 1) begin
      chk(id, "idle_busy",  32'(busy),  32'd0);
      chk(id, "idle_done",  32'(done),  32'd0);
      chk(id, "idle_rd_en", 32'(rd_en), 32'd0);
      chk(id, "idle_state", 32'(dbg),   32'd0);
      if (run_on && rel > 7 * per + 1) begin
        chk(id, "idle_layer", 32'(layer), 32'd6);
        chk(id, "idle_ct",    32'(ct),    32'(!run_mode));
      end else begin
        chk(id, "idle_layer", 32'(layer), 32'(idle_layer));
        chk(id, "idle_ct",    32'(ct),    32'(idle_ct));
      end
    end else if (rel == 7 * per + 1) begin
      chk(id, "done_pulse", 32'(done),  32'd1);
      chk(id, "done_busy",  32'(busy),  32'd0);
      chk(id, "done_rd_en", 32'(rd_en), 32'd0);
      chk(id, "done_state", 32'(dbg),   32'd3);
      chk(id, "done_ct",    32'(ct),    32'(!run_mode));
    end else begin
      n = (rel - 1) / per;
      k = (rel - 1) % per;
      chk(id, "run_busy",  32'(busy),  32'd1);
      chk(id, "run_done",  32'(done),  32'd0);
      chk(id, "run_layer", 32'(layer), 32'(n));
      chk(id, "run_ct",    32'(ct),    32'(!run_mode));
      chk(id, "run_rd_en", 32'(rd_en), 32'(k < 128));
      if (k < 128) begin
        model(run_mode, n, k, ea, eb, et);
        chk(id, "rd_addr_a", 32'(rd_a), 32'(ea));
        chk(id, "rd_addr_b", 32'(rd_b), 32'(eb));
        chk(id, "tw_addr",   32'(tw),   32'(et));
        hz = 1'b0;
        qn = q_size(id);
        for (int i = 0; i < qn; i++) begin
          ent = q_get(id, i);
          if (ent[15:8] == rd_a || ent[15:8] == rd_b ||
              ent[7:0]  == rd_a || ent[7:0]  == rd_b) hz = 1'b1;
        end
        chk(id, "raw_hazard", 32'(hz), 32'd0);
        dup = seen[id][rd_a] | seen[id][rd_b];
        chk(id, "dup_read", 32'(dup), 32'd0);
        seen[id][rd_a] = 1'b1;
        seen[id][rd_b] = 1'b1;
        if (k == 127) begin
          chk(id, "layer_cover", 32'(&seen[id]), 32'd1);
          seen[id] = '0;
        end
        q_push(id, {16'(rel + pipe), ea, eb});
      end
    end
    // write-back side
    ent = 32'd0;
    if (q_size(id) > 0) ent = q_get(id, 0);
    if (q_size(id) > 0 && 32'(ent[31:16]) == 32'(rel)) begin
      q_pop(id);
      chk(id, "wr_en",     32'(wr_en), 32'd1);
      chk(id, "wr_addr_a", 32'(wr_a),  32'(ent[15:8]));
      chk(id, "wr_addr_b", 32'(wr_b),  32'(ent[7:0]));
    end else begin
      chk(id, "wr_en_low", 32'(wr_en), 32'd0);
    end
  endtask

  always @(posedge clk) begin
    #2;
    mon(0, 5, dbg5, bus5.busy, bus5.done, bus5.layer, bus5.ct, bus5.rd_en,
        bus5.rd_addr_a, bus5.rd_addr_b, bus5.tw_addr,
        bus5.wr_en, bus5.wr_addr_a, bus5.wr_addr_b);
    mon(1, 8, dbg8, bus8.busy, bus8.done, bus8.layer, bus8.ct, bus8.rd_en,
        bus8.rd_addr_a, bus8.rd_addr_b, bus8.tw_addr,
        bus8.wr_en, bus8.wr_addr_a, bus8.wr_addr_b);
  end

  // ---------------- driver tasks ----------------
  task automatic zero_chk(input int id, input logic [1:0] dbg, input logic busy,
                          input logic done, input logic [2:0] layer, input logic ct,
                          input logic rd_en, input logic [7:0] rd_a, input logic [7:0] rd_b,
                          input logic [6:0] tw, input logic wr_en,
                          input logic [7:0] wr_a, input logic [7:0] wr_b);
    chk(id, "rst_state",     32'(dbg),   32'd0);
    chk(id, "rst_busy",      32'(busy),  32'd0);
    chk(id, "rst_done",      32'(done),  32'd0);
    chk(id, "rst_layer",     32'(layer), 32'd0);
    chk(id, "rst_ct",        32'(ct),    32'd0);
    chk(id, "rst_rd_en",     32'(rd_en), 32'd0);
    chk(id, "rst_rd_addr_a", 32'(rd_a),  32'd0);
    chk(id, "rst_rd_addr_b", 32'(rd_b),  32'd0);
    chk(id, "rst_tw_addr",   32'(tw),    32'd0);
    chk(id, "rst_wr_en",     32'(wr_en), 32'd0);
    chk(id, "rst_wr_addr_a", 32'(wr_a),  32'd0);
    chk(id, "rst_wr_addr_b", 32'(wr_b),  32'd0);
  endtask

  task automatic zero_both();
    zero_chk(0, dbg5, bus5.busy, bus5.done, bus5.layer, bus5.ct, bus5.rd_en,
             bus5.rd_addr_a, bus5.rd_addr_b, bus5.tw_addr,
             bus5.wr_en, bus5.wr_addr_a, bus5.wr_addr_b);
    zero_chk(1, dbg8, bus8.busy, bus8.done, bus8.layer, bus8.ct, bus8.rd_en,
             bus8.rd_addr_a, bus8.rd_addr_b, bus8.tw_addr,
             bus8.wr_en, bus8.wr_addr_a, bus8.wr_addr_b);
  endtask

  // Start is driven during cycle 0; the first issue is cycle 1.
  task automatic start_run(input logic m);
    @(negedge clk);
    start    = 1'b1;
    mode     = m;
    run_mode = m;
    t_start  = edge_cnt;
    run_on   = 1'b1;
    seen[0]  = '0;
    seen[1]  = '0;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
  endtask

  // Returns at the sample point (2 time units after the edge) of cycle r.
  task automatic wait_rel(input int r);
    while (edge_cnt - t_start < r) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic glitch(input logic m);
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    mode  = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 1'b0;
    seen[0] = '0;
    seen[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_both();
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Forward run with start/mode glitches while busy.
    start_run(1'b0);
    wait_rel(6);
    chk(0, "fwd_l0_bf5_a",  32'(bus5.rd_addr_a), 32'd5);
    chk(0, "fwd_l0_bf5_b",  32'(bus5.rd_addr_b), 32'd133);
    chk(0, "fwd_l0_bf5_tw", 32'(bus5.tw_addr),   32'd1);
    chk(0, "fwd_l0_ct",     32'(bus5.ct),        32'd1);
    glitch(1'b1);
    wait_rel(130);
    glitch(1'b1);
    wait_rel(204);
    chk(0, "fwd_l1_bf70_a",  32'(bus5.rd_addr_a), 32'd134);
    chk(0, "fwd_l1_bf70_b",  32'(bus5.rd_addr_b), 32'd198);
    chk(0, "fwd_l1_bf70_tw", 32'(bus5.tw_addr),   32'd3);
    @(negedge clk);
    mode = 1'b1;
    wait_rel(500);
    @(negedge clk);
    mode = 1'b0;
    wait_rel(900);
    glitch(1'b0);
    wait_rel(926);
    chk(0, "fwd_l6_bf127_a",  32'(bus5.rd_addr_a), 32'd253);
    chk(0, "fwd_l6_bf127_b",  32'(bus5.rd_addr_b), 32'd255);
    chk(0, "fwd_l6_bf127_tw", 32'(bus5.tw_addr),   32'd127);
    wait_rel(931);
    chk(0, "fwd_done_early", 32'(bus5.done), 32'd0);
    wait_rel(932);
    chk(0, "fwd_done_932", 32'(bus5.done), 32'd1);
    chk(0, "fwd_busy_932", 32'(bus5.busy), 32'd0);
    wait_rel(953);
    chk(1, "fwd_done_953", 32'(bus8.done), 32'd1);
    wait_rel(960);

    // Inverse run.
    start_run(1'b1);
    wait_rel(1);
    chk(0, "inv_l0_bf0_a",  32'(bus5.rd_addr_a), 32'd0);
    chk(0, "inv_l0_bf0_b",  32'(bus5.rd_addr_b), 32'd2);
    chk(0, "inv_l0_bf0_tw", 32'(bus5.tw_addr),   32'd127);
    chk(0, "inv_l0_ct",     32'(bus5.ct),        32'd0);
    wait_rel(799);
    chk(0, "inv_l6_bf0_a",  32'(bus5.rd_addr_a), 32'd0);
    chk(0, "inv_l6_bf0_b",  32'(bus5.rd_addr_b), 32'd128);
    chk(0, "inv_l6_bf0_tw", 32'(bus5.tw_addr),   32'd1);
    wait_rel(960);

    // Reset mid-transform, then a fresh full run.
    start_run(1'b0);
    wait_rel(300);
    @(negedge clk);
    rst_n      = 1'b0;
    run_on     = 1'b0;
    idle_layer = 3'd0;
    idle_ct    = 1'b0;
    exp_q.delete();
    exp_q8.delete();
    #1;
    zero_both();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    start_run(1'b0);
    wait_rel(931);
    chk(0, "rerun_done_early", 32'(bus5.done), 32'd0);
    wait_rel(932);
    chk(0, "rerun_done_932", 32'(bus5.done), 32'd1);
    wait_rel(953);
    chk(1, "rerun_done_953", 32'(bus8.done), 32'd1);
    wait_rel(965);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
